// File: rtl/cf_wb_irq_ctrl.sv
// rtl/cf_wb_irq_ctrl.sv - Wishbone interrupt controller with edge-captured flags, mask, clear and gclk enable
// Optional interrupt coalescing (event threshold / timeout) is compiled in with `define CF_IRQ_COALESCE_EN.
module cf_wb_irq_ctrl #(
  parameter int         N_SRC    = 9,
  parameter logic [7:0] REG_PAGE = 8'hFF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [15:0]      adr_i,
  input  logic [31:0]      dat_i,
  input  logic [3:0]       sel_i,
  input  logic             we_i,
  input  logic             stb_i,
  input  logic             cyc_i,
  output logic [31:0]      dat_o,
  output logic             ack_o,
  output logic             hit_o,
  input  logic [N_SRC-1:0] flag_i,
  output logic             clk_en_o,
  output logic             irq_o
);

  localparam logic [7:0] OFF_IM   = 8'h00;
  localparam logic [7:0] OFF_MIS  = 8'h04;
  localparam logic [7:0] OFF_RIS  = 8'h08;
  localparam logic [7:0] OFF_ICR  = 8'h0C;
  localparam logic [7:0] OFF_GCLK = 8'h10;
  localparam logic [7:0] OFF_COAL = 8'h14;

  logic             wb_valid, wr_en;
  logic             ack_q, ack_d;
  logic             gclk_q, gclk_d;
  logic [N_SRC-1:0] im_q, im_d;
  logic [N_SRC-1:0] ris_q, ris_d;
  logic [N_SRC-1:0] flag_q;
  logic [N_SRC-1:0] rise, mis, wr_bits;
  logic [31:0]      coal_rd;
  logic             unused_ok;

  assign hit_o    = (adr_i[15:8] == REG_PAGE);
  assign wb_valid = cyc_i & stb_i & hit_o;
  assign ack_d    = wb_valid & ~ack_q;
  // Writes commit on the edge that raises ack; byte lane 0 gates the whole write.
  assign wr_en    = ack_d & we_i & sel_i[0];
  assign wr_bits  = dat_i[N_SRC-1:0];
  assign rise     = flag_i & ~flag_q;
  assign mis      = ris_q & im_q;
  assign ack_o    = ack_q;
  assign clk_en_o = gclk_q;
  assign unused_ok = ^{dat_i, sel_i};

  always_comb begin
    im_d   = im_q;
    gclk_d = gclk_q;
    ris_d  = ris_q;
    if (wr_en) begin
      case (adr_i[7:0])
        OFF_IM:   im_d   = wr_bits;
        OFF_ICR:  ris_d  = ris_q & ~wr_bits;
        OFF_GCLK: gclk_d = dat_i[0];
        default:  ;
      endcase
    end
    // A new flag edge overrides a coincident clear.
    ris_d = ris_d | rise;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q  <= 1'b0;
      gclk_q <= 1'b0;
      im_q   <= '0;
      ris_q  <= '0;
      flag_q <= '0;
    end else begin
      ack_q  <= ack_d;
      gclk_q <= gclk_d;
      im_q   <= im_d;
      ris_q  <= ris_d;
      flag_q <= flag_i;
    end
  end

  always_comb begin
    dat_o = 32'h0;
    case (adr_i[7:0])
      OFF_IM:   dat_o = 32'(im_q);
      OFF_MIS:  dat_o = 32'(mis);
      OFF_RIS:  dat_o = 32'(ris_q);
      OFF_ICR:  dat_o = 32'h0;
      OFF_GCLK: dat_o = {31'h0, gclk_q};
      OFF_COAL: dat_o = coal_rd;
      default:  dat_o = 32'hDEADBEEF;
    endcase
  end

`ifdef CF_IRQ_COALESCE_EN
  logic [23:0] coal_q, coal_d;
  logic [7:0]  cnt_q, cnt_d, cnt_base;
  logic [15:0] tmr_q, tmr_d;
  logic        irq_q, irq_d;
  logic        mis_nz, evt;
  logic [7:0]  thr;
  logic [15:0] tmo;

  assign mis_nz  = |mis;
  assign evt     = |(rise & im_q);
  assign thr     = coal_q[7:0];
  assign tmo     = coal_q[23:8];
  assign coal_rd = {8'h0, coal_q};
  assign irq_o   = irq_q;

  // The counter restarts from zero whenever nothing is pending, so the event
  // that first makes MIS non-zero is still counted.
  always_comb begin
    coal_d = coal_q;
    if (wr_en && adr_i[7:0] == OFF_COAL) coal_d = dat_i[23:0];
    cnt_base = mis_nz ? cnt_q : 8'h0;
    cnt_d    = (evt && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
    tmr_d    = !mis_nz ? 16'h0 : ((tmr_q == 16'hFFFF) ? tmr_q : tmr_q + 16'd1);
    irq_d    = mis_nz & (irq_q | (thr <= 8'd1) | (cnt_q >= thr) |
                         ((tmo != 16'h0) && (tmr_q >= tmo)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coal_q <= '0;
      cnt_q  <= '0;
      tmr_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      coal_q <= coal_d;
      cnt_q  <= cnt_d;
      tmr_q  <= tmr_d;
      irq_q  <= irq_d;
    end
  end
`else
  assign coal_rd = 32'h0;
  assign irq_o   = |mis;
`endif

endmodule

// File: doc/cf_wb_irq_ctrl.md
CF_WB_IRQ_CTRL -- requirements
Module: cf_wb_irq_ctrl

Interface
REQ-001 Parameter N_SRC, default 9, is the number of interrupt flag sources, legal range 1..32.
REQ-002 Parameter REG_PAGE, default 8'hFF, is the address page (adr_i[15:8]) this block decodes.
REQ-003 Port clk, input, 1, is the single clock; all state is clocked on its rising edge.
REQ-004 Port rst_n, input, 1, is the asynchronous active-low reset.
REQ-005 Port adr_i, input, 16, is the Wishbone byte address.
REQ-006 Port dat_i, input, 32, is the Wishbone write data.
REQ-007 Port sel_i, input, 4, is the byte select; a write with sel_i[0]=0 is ignored but still acked.
REQ-008 Ports we_i, stb_i and cyc_i are 1-bit inputs carrying Wishbone classic write enable, strobe and cycle.
REQ-009 Port dat_o, output, 32, is the read data.
REQ-010 Port ack_o, output, 1, is the Wishbone acknowledge.
REQ-011 Port hit_o, output, 1, is combinational (adr_i[15:8]==REG_PAGE) and is used by the parent to mux dat_o/ack_o.
REQ-012 Port flag_i, input, N_SRC, carries the raw event flags, synchronous to clk.
REQ-013 Port clk_en_o, output, 1, drives GCLK[0] to the parent clock-gating cell.
REQ-014 Port irq_o, output, 1, is the interrupt request.

Function
REQ-015 wb_valid is cyc_i & stb_i & hit_o; ack_o SHALL rise on the first edge where wb_valid & ~ack_o, and fall on the next edge (one-cycle pulse, one-cycle latency; back-to-back accesses are acked every other cycle).
REQ-016 Register writes SHALL take effect on the same edge ack_o rises; accesses with hit_o=0 never assert ack_o.
REQ-017 Map on adr_i[7:0]: 0x00 IM RW; 0x04 MIS RO = RIS & IM; 0x08 RIS RO; 0x0C ICR WO, reads 0; 0x10 GCLK RW, bit 0; 0x14 COAL RW, [7:0] THR, [23:8] TMO; any other offset reads 32'hDEADBEEF, writes ignored, still acked.
REQ-018 Register fields SHALL be N_SRC bits wide and zero-extended on read; write bits at or above N_SRC are ignored.
REQ-019 RIS[k] SHALL set on a rising edge of flag_i[k] (registered previous value 0, current value 1); a level held high sets it only once.
REQ-020 A write of 1 to ICR[k] SHALL clear RIS[k]; if a set and a clear of the same bit coincide, the set wins.
REQ-021 dat_o SHALL be combinational from adr_i and current register values.

Reset
REQ-022 On rst_n=0, asynchronously: IM=0, RIS=0, flag history=0, GCLK=0, COAL=0, counters=0, ack_o=0, irq_o=0, clk_en_o=0.
REQ-023 Reset asserted mid-access SHALL drop ack_o immediately; no partial write survives.

Configuration
REQ-024 Macro CF_IRQ_COALESCE_EN, when defined, SHALL compile in interrupt coalescing per REQ-025..REQ-028.
REQ-025 With CF_IRQ_COALESCE_EN: an 8-bit event counter increments, saturating at 255, on each cycle in which any bit of (new RIS sets & IM) is 1.
REQ-026 With CF_IRQ_COALESCE_EN: a 16-bit timer increments, saturating at 65535, on each cycle MIS!=0.
REQ-027 With CF_IRQ_COALESCE_EN: irq_o is registered and set when MIS!=0 and (THR<=1, or count>=THR, or (TMO!=0 and timer>=TMO)); it stays set while MIS!=0.
REQ-028 With CF_IRQ_COALESCE_EN: when MIS==0, the counter and timer clear and irq_o falls on the next edge.
REQ-029 Without CF_IRQ_COALESCE_EN: irq_o = |MIS combinationally, COAL reads 0, COAL writes are ignored, and no counter or timer logic exists.

Verification
REQ-030 Reset, then read 0xFF00/0xFF04/0xFF08/0xFF10/0xFF14/0xFF20 -> 0, 0, 0, 0, 0, 32'hDEADBEEF; each ack_o is one cycle wide, one cycle after stb_i.
REQ-031 IM=0x1FF, pulse flag_i[3] then hold flag_i[5] high for 10 cycles -> RIS=0x028 and MIS=0x028; write ICR=0x008 -> RIS=0x020; flag_i[5] still high does not re-set the bit after ICR=0x020.
REQ-032 Drive a flag_i[0] rising edge on the same edge as an ICR=0x001 write -> RIS[0]=1.
REQ-033 Access with adr_i=0x1000 -> hit_o=0, ack_o stays 0 for 5 cycles; IM write with sel_i=0 -> IM unchanged, ack_o pulses.
REQ-034 With CF_IRQ_COALESCE_EN, COAL THR=3, TMO=0 -> irq_o rises only after the 3rd unmasked event; with THR=8, TMO=20 and a single event -> irq_o rises 20-21 cycles later; ICR clearing all bits -> irq_o low next cycle.
REQ-035 Without the macro -> irq_o follows |MIS in the same cycle, and a COAL write then read returns 0.
